// File: rtl/regfiletmp_ctrl.sv
// regfiletmp_ctrl
// In-order allocation / commit sequencer for the 32-entry speculative
// temporary register file. The file is run as a circular buffer: dispatch
// takes the tail tag, CDB completions become read-modify-write updates of
// the addressed entry, and completed entries retire from the head in order.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   flush               discard every live entry (highest priority)
//   disp_*              dispatch request/payload, disp_ready/disp_tag back
//   cdb_*               completion broadcast (tag + result bit)
//   New_entry, Update_entry, Waddr, Data_In
//                       the file's single write port (registered strobes)
//   Rd_Addr1/Data_out1  head read port used for commit
//   Rd_Addr2/Data_out2  CDB read port used for the update read
//   commit_*            one-cycle retire pulse and retired fields
//   count, full, empty  occupancy
// Entry layout: rd[41:37] pc[36:5] type[4:3] spec_data[2] spec_valid[1] valid[0]
module regfiletmp_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          disp_req,
  input  logic [4:0]    disp_rd,
  input  logic [31:0]   disp_pc,
  input  logic [1:0]    disp_type,
  output logic          disp_ready,
  output logic [AW-1:0] disp_tag,
  input  logic          cdb_valid,
  input  logic [AW-1:0] cdb_tag,
  input  logic          cdb_spec_data,
  output logic          New_entry,
  output logic          Update_entry,
  output logic [AW-1:0] Waddr,
  output logic [41:0]   Data_In,
  output logic [AW-1:0] Rd_Addr1,
  input  logic [41:0]   Data_out1,
  output logic [AW-1:0] Rd_Addr2,
  input  logic [41:0]   Data_out2,
  output logic          commit_valid,
  output logic [4:0]    commit_rd,
  output logic [31:0]   commit_pc,
  output logic          commit_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    head_reg, tail_reg;
  logic [AW:0]      count_reg, count_next;
  logic [DEPTH-1:0] busy_reg, busy_next;
  logic [DEPTH-1:0] done_reg, done_next;
  logic [DEPTH-1:0] spec_reg, spec_next;
  logic [DEPTH-1:0] alloc_hit, retire_hit, cdb_hit;

  logic        disp_accept;
  logic        cdb_accept;
  logic        commit_fire;
  logic [38:0] upd_base;

  // Status bits of the file entries are never consumed here; the busy/done
  // vectors are the authoritative liveness state.
  logic unused_status;
  assign unused_status = ^{Data_out1[2:0], Data_out2[2:0]};

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign Rd_Addr1 = head_reg;
  assign Rd_Addr2 = cdb_tag;
  assign disp_tag = tail_reg;

  // The CDB owns the write port whenever it is asserting, so dispatch backs off.
  assign disp_ready  = !full && !cdb_valid && !flush;
  assign disp_accept = disp_req && disp_ready;
  assign cdb_accept  = cdb_valid && busy_reg[cdb_tag] && !done_reg[cdb_tag] && !flush;
  // done[head] is the registered flag, so a CDB to the head this cycle can
  // only retire it next cycle.
  assign commit_fire = !empty && done_reg[head_reg] && !flush;

  // A CDB one cycle after dispatch reads the entry while its New_entry write
  // is still on the port; take the upper fields from the pending write then.
  always_comb begin
    upd_base = Data_out2[41:3];
    if (New_entry && (Waddr == cdb_tag)) begin
      upd_base = Data_In[41:3];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi]  = disp_accept && (tail_reg == AW'(gi));
      assign retire_hit[gi] = commit_fire && (head_reg == AW'(gi));
      assign cdb_hit[gi]    = cdb_accept  && (cdb_tag  == AW'(gi));
      assign spec_next[gi]  = cdb_hit[gi] ? cdb_spec_data : spec_reg[gi];
    end
  endgenerate

  // Allocation, completion and retirement never target the same entry in one
  // cycle (tail==head only when empty or full), so simple set/clear suffices.
  always_comb begin
    busy_next = (busy_reg | alloc_hit) & ~retire_hit;
    done_next = (done_reg | cdb_hit) & ~alloc_hit & ~retire_hit;
    if (flush) begin
      busy_next = '0;
      done_next = '0;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (disp_accept && !commit_fire) begin
      count_next = count_reg + 1'b1;
    end else if (commit_fire && !disp_accept) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      busy_reg     <= '0;
      done_reg     <= '0;
      spec_reg     <= '0;
      New_entry    <= 1'b0;
      Update_entry <= 1'b0;
      commit_valid <= 1'b0;
      Waddr        <= '0;
      Data_In      <= '0;
      commit_rd    <= '0;
      commit_pc    <= '0;
      commit_data  <= 1'b0;
    end else begin
      count_reg <= count_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      spec_reg  <= spec_next;

      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (commit_fire) head_reg <= head_reg + 1'b1;
        if (disp_accept) tail_reg <= tail_reg + 1'b1;
      end

      // Accept terms already exclude flush, so strobes drop after a flush.
      New_entry    <= disp_accept;
      Update_entry <= cdb_accept;
      commit_valid <= commit_fire;

      if (cdb_accept) begin
        Waddr   <= cdb_tag;
        Data_In <= {upd_base, cdb_spec_data, 1'b1, 1'b1};
      end else if (disp_accept) begin
        Waddr   <= tail_reg;
        Data_In <= {disp_rd, disp_pc, disp_type, 1'b0, 1'b0, 1'b1};
      end

      if (commit_fire) begin
        commit_rd   <= Data_out1[41:37];
        commit_pc   <= Data_out1[36:5];
        commit_data <= spec_reg[head_reg];
      end
    end
  end

endmodule

// File: tb/tb_regfiletmp_ctrl.sv
// Bench for regfiletmp_ctrl: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model of
// the in-order buffer. The register file itself is modelled as a memory with
// asynchronous read and a write on the rising edge.
module tb_regfiletmp_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clock, reset, flush, disp_req;
  logic [4:0]    disp_rd;
  logic [31:0]   disp_pc;
  logic [1:0]    disp_type;
  logic          disp_ready;
  logic [AW-1:0] disp_tag;
  logic          cdb_valid;
  logic [AW-1:0] cdb_tag;
  logic          cdb_spec_data;
  logic          New_entry, Update_entry;
  logic [AW-1:0] Waddr;
  logic [41:0]   Data_In;
  logic [AW-1:0] Rd_Addr1, Rd_Addr2;
  logic [41:0]   Data_out1, Data_out2;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [31:0]   commit_pc;
  logic          commit_data;
  logic [AW:0]   count;
  logic          full, empty;

  regfiletmp_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_req(disp_req), .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_type(disp_type),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_spec_data(cdb_spec_data),
    .New_entry(New_entry), .Update_entry(Update_entry), .Waddr(Waddr), .Data_In(Data_In),
    .Rd_Addr1(Rd_Addr1), .Data_out1(Data_out1), .Rd_Addr2(Rd_Addr2), .Data_out2(Data_out2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pc(commit_pc),
    .commit_data(commit_data), .count(count), .full(full), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model
  logic [41:0] mem [DEPTH];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (New_entry || Update_entry) begin
      mem[Waddr] <= Data_In;
    end
  end
  assign Data_out1 = mem[Rd_Addr1];
  assign Data_out2 = mem[Rd_Addr2];

  // Reference model: program-ordered queue of live entries
  typedef struct {
    logic [AW-1:0] tag;
    logic [4:0]    rd;
    logic [31:0]   pc;
    logic [1:0]    typ;
    logic          done;
    logic          spec;
  } ent_t;

  ent_t          rob[$];
  logic [AW-1:0] next_tag;
  logic          e_new, e_upd, e_cv;
  logic [AW-1:0] e_waddr;
  logic [41:0]   e_din;
  logic [4:0]    e_crd;
  logic [31:0]   e_cpc;
  logic          e_cdata;

  logic          obs_ready;
  logic [AW-1:0] obs_tag;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    next_tag = '0;
    e_new = 1'b0; e_upd = 1'b0; e_cv = 1'b0;
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_cycle(input logic f, input logic req, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [1:0] typ,
                             input logic cv, input logic [AW-1:0] ct, input logic sd);
    logic do_commit;
    logic acc;
    ent_t e;
    e_new = 1'b0; e_upd = 1'b0; e_cv = 1'b0;
    if (f) begin
      rob.delete();
      next_tag = '0;
    end else begin
      do_commit = (rob.size() > 0) && rob[0].done;
      acc = req && (rob.size() < DEPTH) && !cv;
      if (cv) begin
        for (int i = 0; i < rob.size(); i++) begin
          if (rob[i].tag == ct && !rob[i].done) begin
            e = rob[i];
            e.done = 1'b1;
            e.spec = sd;
            rob[i] = e;
            e_upd = 1'b1;
            e_waddr = ct;
            e_din = {e.rd, e.pc, e.typ, sd, 2'b11};
          end
        end
      end
      if (acc) begin
        e.tag = next_tag; e.rd = rd; e.pc = pc; e.typ = typ;
        e.done = 1'b0; e.spec = 1'b0;
        rob.push_back(e);
        e_new = 1'b1;
        e_waddr = next_tag;
        e_din = {rd, pc, typ, 3'b001};
        next_tag = next_tag + 1'b1;
      end
      if (do_commit) begin
        e_cv = 1'b1;
        e_crd = rob[0].rd;
        e_cpc = rob[0].pc;
        e_cdata = rob[0].spec;
        void'(rob.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    chk("New_entry", New_entry, e_new);
    chk("Update_entry", Update_entry, e_upd);
    chk("commit_valid", commit_valid, e_cv);
    if (e_new || e_upd) begin
      chk("Waddr", Waddr, e_waddr);
      chk("Data_In", Data_In, e_din);
    end
    if (e_cv) begin
      chk("commit_rd", commit_rd, e_crd);
      chk("commit_pc", commit_pc, e_cpc);
      chk("commit_data", commit_data, e_cdata);
    end
    chk("count", count, rob.size());
    chk("full", full, rob.size() == DEPTH);
    chk("empty", empty, rob.size() == 0);
    if (rob.size() > 0) chk("Rd_Addr1", Rd_Addr1, rob[0].tag);
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance the model, then check registered outputs at the next falling edge.
  task automatic step(input logic f, input logic req, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [1:0] typ,
                      input logic cv, input logic [AW-1:0] ct, input logic sd);
    logic m_ready;
    flush = f; disp_req = req; disp_rd = rd; disp_pc = pc; disp_type = typ;
    cdb_valid = cv; cdb_tag = ct; cdb_spec_data = sd;
    #1;
    m_ready = (rob.size() < DEPTH) && !cv && !f;
    obs_ready = disp_ready;
    obs_tag = disp_tag;
    chk("disp_ready", disp_ready, m_ready);
    chk("disp_tag", disp_tag, next_tag);
    if (cv) chk("Rd_Addr2", Rd_Addr2, ct);
    model_cycle(f, req, rd, pc, typ, cv, ct, sd);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic          f, req;
    logic [4:0]    rd;
    logic [31:0]   pc;
    logic [1:0]    typ;
    logic          cv;
    logic [AW-1:0] ct;
    logic          sd;
    logic          x_ready;
    logic [AW-1:0] x_tag;
    logic          x_new, x_upd, x_cv;
    logic [4:0]    x_crd;
    logic [AW:0]   x_count;
  } vec_t;

  function automatic vec_t mkv(logic req, logic [4:0] rd, logic [31:0] pc,
                               logic cv, logic [AW-1:0] ct, logic sd,
                               logic x_ready, logic [AW-1:0] x_tag, logic x_new,
                               logic x_upd, logic x_cv, logic [4:0] x_crd, logic [AW:0] x_count);
    vec_t v;
    v.f = 1'b0; v.req = req; v.rd = rd; v.pc = pc; v.typ = 2'b10;
    v.cv = cv; v.ct = ct; v.sd = sd;
    v.x_ready = x_ready; v.x_tag = x_tag; v.x_new = x_new; v.x_upd = x_upd;
    v.x_cv = x_cv; v.x_crd = x_crd; v.x_count = x_count;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int req_pct;
    int cv_pct;
    logic [AW-1:0] rtag;
    n_vec = 0;
    n_err = 0;

    //        req rd   pc       cv ct  sd | rdy tag new upd cv crd cnt
    tbl[0]  = mkv(1, 1, 32'h100, 0, 0, 0,   1,  0,  1,  0,  0, 0,  1);
    tbl[1]  = mkv(1, 2, 32'h104, 0, 0, 0,   1,  1,  1,  0,  0, 0,  2);
    tbl[2]  = mkv(1, 3, 32'h108, 0, 0, 0,   1,  2,  1,  0,  0, 0,  3);
    tbl[3]  = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  0, 0,  3);
    tbl[4]  = mkv(0, 0, 32'h0,   1, 0, 1,   0,  3,  0,  1,  0, 0,  3);
    tbl[5]  = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  1, 1,  2);
    tbl[6]  = mkv(0, 0, 32'h0,   1, 2, 0,   0,  3,  0,  1,  0, 0,  2);
    tbl[7]  = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  0, 0,  2);
    tbl[8]  = mkv(0, 0, 32'h0,   1, 1, 1,   0,  3,  0,  1,  0, 0,  2);
    tbl[9]  = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  1, 2,  1);
    tbl[10] = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  1, 3,  0);
    tbl[11] = mkv(0, 0, 32'h0,   0, 0, 0,   1,  3,  0,  0,  0, 0,  0);
    tbl[12] = mkv(0, 0, 32'h0,   1, 5, 1,   0,  3,  0,  0,  0, 0,  0);
    tbl[13] = mkv(1, 7, 32'h200, 1, 5, 1,   0,  3,  0,  0,  0, 0,  0);

    // Reset
    reset = 1'b0; flush = 1'b0; disp_req = 1'b0; disp_rd = '0; disp_pc = '0;
    disp_type = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_spec_data = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_New_entry", New_entry, 0);
    chk("rst_Update_entry", Update_entry, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_Waddr", Waddr, 0);
    chk("rst_Data_In", Data_In, 0);
    chk("rst_commit_fields", {commit_rd, commit_pc, commit_data}, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_Rd_Addr1", Rd_Addr1, 0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].f, tbl[i].req, tbl[i].rd, tbl[i].pc, tbl[i].typ,
           tbl[i].cv, tbl[i].ct, tbl[i].sd);
      chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].x_ready);
      chk($sformatf("tbl%0d_tag", i), obs_tag, tbl[i].x_tag);
      chk($sformatf("tbl%0d_new", i), New_entry, tbl[i].x_new);
      chk($sformatf("tbl%0d_upd", i), Update_entry, tbl[i].x_upd);
      chk($sformatf("tbl%0d_cv", i), commit_valid, tbl[i].x_cv);
      if (tbl[i].x_cv) chk($sformatf("tbl%0d_crd", i), commit_rd, tbl[i].x_crd);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].x_count);
    end

    // Fill all 32 entries; tail wraps back to where it started
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 5'($urandom), $urandom, 2'($urandom), 1'b0, '0, 1'b0);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);
    step(1'b0, 1'b1, 5'd9, 32'h900, 2'd1, 1'b0, '0, 1'b0);
    chk("full_ready", obs_ready, 0);
    chk("full_no_new", New_entry, 0);
    // Complete the head (tag 3), it retires next cycle while still full
    step(1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 5'd3, 1'b1);
    step(1'b0, 1'b1, 5'd10, 32'ha00, 2'd2, 1'b0, '0, 1'b0);
    chk("retire_while_full_ready", obs_ready, 0);
    chk("retire_while_full_cv", commit_valid, 1);
    // CDB and dispatch together: only the update fires
    step(1'b0, 1'b1, 5'd11, 32'hb00, 2'd3, 1'b1, 5'd4, 1'b0);
    chk("cdb_prio_new", New_entry, 0);
    chk("cdb_prio_upd", Update_entry, 1);
    // Dispatch and commit in the same cycle: count unchanged, tag 3 reused
    step(1'b0, 1'b1, 5'd12, 32'hc00, 2'd0, 1'b0, '0, 1'b0);
    chk("same_cycle_count", count, 31);
    chk("tag_reuse", obs_tag, 3);
    chk("same_cycle_new", New_entry, 1);
    chk("same_cycle_cv", commit_valid, 1);

    // Flush with entries live and a commit about to fire
    step(1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 5'd5, 1'b1);
    step(1'b1, 1'b1, 5'd13, 32'hd00, 2'd1, 1'b0, '0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_strobes", {New_entry, Update_entry, commit_valid}, 0);
    idle();

    // Asynchronous reset while New_entry is high
    step(1'b0, 1'b1, 5'd14, 32'he00, 2'd2, 1'b0, '0, 1'b0);
    chk("pre_reset_new", New_entry, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_new", New_entry, 0);
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic, alternating light and heavy dispatch phases
    for (int k = 0; k < 6; k++) begin
      req_pct = (k % 2 == 1) ? 85 : 50;
      cv_pct  = (k % 2 == 1) ? 15 : 45;
      for (int c = 0; c < 500; c++) begin
        if (rob.size() > 0 && $urandom_range(9) < 8)
          rtag = rob[$urandom_range(rob.size() - 1)].tag;
        else
          rtag = AW'($urandom);
        step(($urandom_range(99) < 2), ($urandom_range(99) < req_pct),
             5'($urandom), $urandom, 2'($urandom),
             ($urandom_range(99) < cv_pct), rtag, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
